reg_file_scoreboard: RTL and testbench
======================================

# reg_file_scoreboard

Architectural register file plus in-flight-write scoreboard that terminates the writeback interface of the 5-stage pipeline. It stores the writeback result (`WB_EN_In`, `Dest_In`, `WB_Value`) and serves two combinational read ports to the ID stage. It also tracks, per register, how many issued instructions still owe a write, and raises `Hazard` when an ID-stage source operand is not yet written back. Sits beside the ID stage; its write side is driven directly by the WB stage outputs.

## Interface
Parameters:
- `WIDTH`, 32, data width of each register
- `MAX_INFLIGHT`, 3, maximum outstanding writes per register (counter saturation limit)

Ports:
- `clk`  input  1  clock; all state updates on rising edge
- `rst`  input  1  synchronous, active-high reset
- `WB_EN_In`  input  1  writeback valid this cycle
- `Dest_In`  input  4  writeback destination register
- `WB_Value`  input  WIDTH  writeback data
- `Issue_EN`  input  1  ID stage issues an instruction that will write `Issue_Dest`
- `Issue_Dest`  input  4  destination of issued instruction
- `Flush`  input  1  clear all pending counters (branch flush); register contents kept
- `Src1`, `Src2`  input  4 each  read addresses
- `Src1_Valid`, `Src2_Valid`  input  1 each  operand actually used (gates `Hazard`)
- `Reg1`, `Reg2`  output  WIDTH each  read data, combinational
- `Hazard`  output  1  combinational stall request
- `Overflow_Err`, `Underflow_Err`  output  1 each  sticky error flags

## Operation
- Storage: R0–R14, `WIDTH` bits each. Address 15 is not stored: writes to 15 ignored, reads of 15 return 0, issues to 15 ignored, 15 never hazardous.
- Write: on rising edge, if `WB_EN_In` and `Dest_In`≠15, R[`Dest_In`] ← `WB_Value`.
- Read: `Reg1` = R[`Src1`], `Reg2` = R[`Src2`], combinational (bypass rule under Configuration).
- Scoreboard: per-register 2-bit counter `cnt[r]`, r = 0..14.
  - issue only (`Issue_EN`, `Issue_Dest`=r): `cnt[r]`+1
  - retire only (`WB_EN_In`, `Dest_In`=r): `cnt[r]`−1
  - issue and retire to the same r in one cycle: `cnt[r]` unchanged
  - issue and retire to different registers: both updates apply
  - issue when `cnt[r]`=`MAX_INFLIGHT` (no retire to r): counter holds, `Overflow_Err` ← 1
  - retire when `cnt[r]`=0 (no issue to r): counter holds at 0, `Underflow_Err` ← 1
- `Flush`: all counters ← 0 at the edge, overriding every issue/retire counter update that cycle. The register write that cycle still occurs. No error flags are set by a retire/issue collapsed by the flush.
- `Hazard` = (`Src1_Valid` ∧ pend(`Src1`)) ∨ (`Src2_Valid` ∧ pend(`Src2`)), where pend(r) = `cnt[r]`≠0 (bypass rule under Configuration). `Issue_EN` in the same cycle does not affect `Hazard`.
- Error flags stay set until `rst`.

## Timing
- Reset (synchronous, `rst`=1 at rising edge): R0–R14 ← 0, all `cnt` ← 0, `Overflow_Err`=`Underflow_Err`=0. Result: `Reg1`=`Reg2`=0 and `Hazard`=0.
- `rst` overrides `Flush`, write, issue and retire in the same cycle.
- Write latency: data visible on `Reg1`/`Reg2` in the cycle after the write edge, or in the same cycle with bypass.
- Counter change is visible to `Hazard` in the cycle after the issue/retire edge.
- Read/hazard path is purely combinational from `Src*`, state and the WB inputs; no registered outputs.

## Configuration
- `WB_BYPASS_EN` defined:
  - if `WB_EN_In` ∧ `Dest_In`=`SrcN` ∧ `SrcN`≠15, then `RegN` = `WB_Value` in the same cycle
  - pend(r) = (`cnt[r]` − (`WB_EN_In` ∧ `Dest_In`=r)) ≠ 0, i.e. a retiring last write clears the hazard in the same cycle
- Not defined: reads return the stored value only, and pend(r) = `cnt[r]`≠0. The ID stage sees the write and the hazard release one cycle later.

## Test plan
- Reset, then read all 16 addresses -> all 0, `Hazard`=0, both error flags 0.
- Issue R3; next cycle `Src1`=3, `Src1_Valid`=1 -> `Hazard`=1. Then WB R3 = 0xDEADBEEF -> bypass: `Reg1`=0xDEADBEEF and `Hazard`=0 in that cycle; no bypass: both change one cycle later.
- Issue R5 ×3, then a 4th issue -> `cnt`=3 and `Overflow_Err`=1. Three WBs to R5 -> `Hazard` clears after the third.
- Same-cycle issue R7 and WB R7 with `cnt[7]`=1 -> `cnt[7]` stays 1, `Hazard` stays 1 for `Src2`=7. `Src2_Valid`=0 -> `Hazard`=0.
- Issue R1, R2, then `Flush` with a simultaneous WB R1 = 0x55 -> all counters 0, R1 = 0x55, `Underflow_Err`=0. A later WB R2 -> `Underflow_Err`=1.
- WB R15 = 0x1234 and issue R15 -> read R15 = 0, `Hazard`=0. Assert `rst` mid-sequence with pending counts -> all state cleared at that edge.

Source files
------------

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: 15-entry architectural register file (R0-R14, address 15
// unmapped) with a per-register count of outstanding writes that drives a
// combinational operand hazard for the ID stage.
// Optional feature macro: WB_BYPASS_EN forwards the WB-stage write to the read
// ports and releases the hazard of a retiring last write in the same cycle.
module reg_file_scoreboard #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned MAX_INFLIGHT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             WB_EN_In,
  input  logic [3:0]       Dest_In,
  input  logic [WIDTH-1:0] WB_Value,
  input  logic             Issue_EN,
  input  logic [3:0]       Issue_Dest,
  input  logic             Flush,
  input  logic [3:0]       Src1,
  input  logic [3:0]       Src2,
  input  logic             Src1_Valid,
  input  logic             Src2_Valid,
  output logic [WIDTH-1:0] Reg1,
  output logic [WIDTH-1:0] Reg2,
  output logic             Hazard,
  output logic             Overflow_Err,
  output logic             Underflow_Err
);

  localparam int unsigned NREGS   = 15;
  localparam logic [3:0]  NO_REG  = 4'd15;
  localparam logic [1:0]  MAX_CNT = 2'(MAX_INFLIGHT);

  logic [WIDTH-1:0] regs     [NREGS];
  logic [1:0]       cnt      [NREGS];
  logic [1:0]       cnt_next [NREGS];
  logic [NREGS-1:0] issue_hit;
  logic [NREGS-1:0] retire_hit;
  logic [15:0]      pend;
  logic             ovf_set;
  logic             unf_set;

  // Decode issue and retire targets; address 15 never matches a stored register
  always_comb begin
    issue_hit  = '0;
    retire_hit = '0;
    for (int unsigned r = 0; r < NREGS; r++) begin
      issue_hit[r]  = Issue_EN && (Issue_Dest == 4'(r));
      retire_hit[r] = WB_EN_In && (Dest_In == 4'(r));
    end
  end

  // Next outstanding-write counts and error events; a flush discards both
  always_comb begin
    ovf_set = 1'b0;
    unf_set = 1'b0;
    for (int unsigned r = 0; r < NREGS; r++) begin
      cnt_next[r] = cnt[r];
      case ({issue_hit[r], retire_hit[r]})
        2'b10: begin
          if (cnt[r] == MAX_CNT) ovf_set = 1'b1;
          else                   cnt_next[r] = cnt[r] + 2'd1;
        end
        2'b01: begin
          if (cnt[r] == 2'd0) unf_set = 1'b1;
          else                cnt_next[r] = cnt[r] - 2'd1;
        end
        default: ;
      endcase
    end
    if (Flush) begin
      for (int unsigned r = 0; r < NREGS; r++) cnt_next[r] = '0;
      ovf_set = 1'b0;
      unf_set = 1'b0;
    end
  end

  // Register file write, counter update and sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
      Overflow_Err  <= 1'b0;
      Underflow_Err <= 1'b0;
    end else begin
      if (WB_EN_In && (Dest_In != NO_REG)) regs[Dest_In] <= WB_Value;
      cnt <= cnt_next;
      if (ovf_set) Overflow_Err  <= 1'b1;
      if (unf_set) Underflow_Err <= 1'b1;
    end
  end

  // Combinational read ports, optionally forwarding the WB-stage write
  always_comb begin
    Reg1 = '0;
    Reg2 = '0;
    if (Src1 != NO_REG) Reg1 = regs[Src1];
    if (Src2 != NO_REG) Reg2 = regs[Src2];
`ifdef WB_BYPASS_EN
    if (WB_EN_In && (Dest_In == Src1) && (Src1 != NO_REG)) Reg1 = WB_Value;
    if (WB_EN_In && (Dest_In == Src2) && (Src2 != NO_REG)) Reg2 = WB_Value;
`endif
  end

  // Pending-write status per address; entry 15 stays clear
  always_comb begin
    pend = '0;
    for (int unsigned r = 0; r < NREGS; r++) begin
`ifdef WB_BYPASS_EN
      // cnt - retire != 0 reduces to cnt != retire
      pend[r] = (cnt[r] != {1'b0, retire_hit[r]});
`else
      pend[r] = (cnt[r] != 2'd0);
`endif
    end
  end

  // Stall request for any used source operand with an outstanding write
  always_comb begin
    Hazard = (Src1_Valid && pend[Src1]) || (Src2_Valid && pend[Src2]);
  end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Testbench for reg_file_scoreboard: directed scenarios plus randomized
// traffic, all checked against an array-based reference model.
module tb_reg_file_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        WB_EN_In = 1'b0;
  logic [3:0]  Dest_In = '0;
  logic [31:0] WB_Value = '0;
  logic        Issue_EN = 1'b0;
  logic [3:0]  Issue_Dest = '0;
  logic        Flush = 1'b0;
  logic [3:0]  Src1 = '0;
  logic [3:0]  Src2 = '0;
  logic        Src1_Valid = 1'b0;
  logic        Src2_Valid = 1'b0;
  logic [31:0] Reg1;
  logic [31:0] Reg2;
  logic        Hazard;
  logic        Overflow_Err;
  logic        Underflow_Err;

  int n_pass  = 0;
  int n_total = 0;

  reg_file_scoreboard #(.WIDTH(32), .MAX_INFLIGHT(3)) dut (
    .clk(clk), .rst(rst),
    .WB_EN_In(WB_EN_In), .Dest_In(Dest_In), .WB_Value(WB_Value),
    .Issue_EN(Issue_EN), .Issue_Dest(Issue_Dest), .Flush(Flush),
    .Src1(Src1), .Src2(Src2), .Src1_Valid(Src1_Valid), .Src2_Valid(Src2_Valid),
    .Reg1(Reg1), .Reg2(Reg2), .Hazard(Hazard),
    .Overflow_Err(Overflow_Err), .Underflow_Err(Underflow_Err)
  );

  always #5 clk = ~clk;

  // Reference model: register values, outstanding-write counts, sticky flags
  logic [31:0] mregs [16];
  int          mcnt  [16];
  bit          movf;
  bit          munf;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        mregs[i] = '0;
        mcnt[i]  = 0;
      end
      movf = 0;
      munf = 0;
    end else begin
      bit iss;
      bit ret;
      iss = Issue_EN && Issue_Dest != 15;
      ret = WB_EN_In && Dest_In != 15;
      if (ret) mregs[Dest_In] = WB_Value;
      if (Flush) begin
        for (int i = 0; i < 16; i++) mcnt[i] = 0;
      end else if (iss && ret && Issue_Dest == Dest_In) begin
        // issue and retire cancel out
      end else begin
        if (iss) begin
          if (mcnt[Issue_Dest] == 3) movf = 1;
          else mcnt[Issue_Dest] = mcnt[Issue_Dest] + 1;
        end
        if (ret) begin
          if (mcnt[Dest_In] == 0) munf = 1;
          else mcnt[Dest_In] = mcnt[Dest_In] - 1;
        end
      end
    end
  end

  function automatic logic [31:0] m_read(input logic [3:0] a);
    if (a == 15) return '0;
`ifdef WB_BYPASS_EN
    if (WB_EN_In && Dest_In == a) return WB_Value;
`endif
    return mregs[a];
  endfunction

  function automatic bit m_pend(input logic [3:0] a);
    int c;
    if (a == 15) return 0;
    c = mcnt[a];
`ifdef WB_BYPASS_EN
    if (WB_EN_In && Dest_In == a) c = c - 1;
`endif
    return c != 0;
  endfunction

  function automatic bit m_hazard();
    return (Src1_Valid && m_pend(Src1)) || (Src2_Valid && m_pend(Src2));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    WB_EN_In = 0; Issue_EN = 0; Flush = 0; rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; WB_EN_In = 1; Dest_In = 2; WB_Value = 32'hFFFF_FFFF;
    Issue_EN = 1; Issue_Dest = 2;
    tick();
    idle();
    Src1_Valid = 1; Src2_Valid = 1;
    for (int a = 0; a < 16; a++) begin
      Src1 = 4'(a); Src2 = 4'(15 - a);
      #1;
      n_total++;
      if (Reg1 !== 32'h0 || Reg2 !== 32'h0 || Hazard !== 1'b0) begin
        $display("FAIL reset_read addr=%0d got Reg1=%h Reg2=%h Hazard=%b exp 0/0/0", a, Reg1, Reg2, Hazard);
      end else n_pass++;
    end
    n_total++;
    if (Overflow_Err !== 1'b0 || Underflow_Err !== 1'b0) begin
      $display("FAIL reset_flags got ovf=%b unf=%b exp 0/0", Overflow_Err, Underflow_Err);
    end else n_pass++;
  endtask

  task automatic test_hazard_wb();
    Issue_EN = 1; Issue_Dest = 3;
    tick();
    idle();
    Src1 = 3; Src1_Valid = 1; Src2_Valid = 0;
    #1;
    n_total++;
    if (Hazard !== 1'b1) $display("FAIL issue_hazard got=%b exp=1", Hazard);
    else n_pass++;
    WB_EN_In = 1; Dest_In = 3; WB_Value = 32'hDEAD_BEEF;
    #1;
    n_total++;
    if (Reg1 !== m_read(3) || Hazard !== m_hazard()) begin
      $display("FAIL wb_same_cycle got Reg1=%h Hazard=%b exp Reg1=%h Hazard=%b", Reg1, Hazard, m_read(3), m_hazard());
    end else n_pass++;
    tick();
    idle();
    #1;
    n_total++;
    if (Reg1 !== 32'hDEAD_BEEF || Hazard !== 1'b0) begin
      $display("FAIL wb_next_cycle got Reg1=%h Hazard=%b exp DEADBEEF/0", Reg1, Hazard);
    end else n_pass++;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) begin
      Issue_EN = 1; Issue_Dest = 5;
      tick();
    end
    idle();
    Src1 = 5; Src1_Valid = 1;
    #1;
    n_total++;
    if (Overflow_Err !== 1'b1 || Underflow_Err !== 1'b0 || Hazard !== 1'b1) begin
      $display("FAIL overflow got ovf=%b unf=%b Hazard=%b exp 1/0/1", Overflow_Err, Underflow_Err, Hazard);
    end else n_pass++;
    for (int i = 0; i < 3; i++) begin
      WB_EN_In = 1; Dest_In = 5; WB_Value = 32'(i + 100);
      #1;
      n_total++;
      if (Hazard !== m_hazard()) $display("FAIL overflow_drain step=%0d got=%b exp=%b", i, Hazard, m_hazard());
      else n_pass++;
      tick();
    end
    idle();
    #1;
    n_total++;
    if (Hazard !== 1'b0 || Underflow_Err !== 1'b0) begin
      $display("FAIL overflow_drained got Hazard=%b unf=%b exp 0/0", Hazard, Underflow_Err);
    end else n_pass++;
  endtask

  task automatic test_same_cycle();
    Issue_EN = 1; Issue_Dest = 7;
    tick();
    WB_EN_In = 1; Dest_In = 7; WB_Value = 32'h7777;
    tick();
    idle();
    Src1_Valid = 0; Src2 = 7; Src2_Valid = 1;
    #1;
    n_total++;
    if (Hazard !== 1'b1) $display("FAIL same_cycle_pending got=%b exp=1", Hazard);
    else n_pass++;
    Src2_Valid = 0;
    #1;
    n_total++;
    if (Hazard !== 1'b0) $display("FAIL same_cycle_invalid got=%b exp=0", Hazard);
    else n_pass++;
    WB_EN_In = 1; Dest_In = 7;
    tick();
    idle();
  endtask

  task automatic test_flush();
    Issue_EN = 1; Issue_Dest = 1;
    tick();
    Issue_Dest = 2;
    tick();
    Issue_EN = 0; Flush = 1; WB_EN_In = 1; Dest_In = 1; WB_Value = 32'h55;
    tick();
    idle();
    Src1 = 1; Src1_Valid = 1; Src2 = 2; Src2_Valid = 1;
    #1;
    n_total++;
    if (Hazard !== 1'b0 || Reg1 !== 32'h55 || Underflow_Err !== 1'b0) begin
      $display("FAIL flush got Hazard=%b Reg1=%h unf=%b exp 0/00000055/0", Hazard, Reg1, Underflow_Err);
    end else n_pass++;
    WB_EN_In = 1; Dest_In = 2; WB_Value = 32'h22;
    tick();
    idle();
    #1;
    n_total++;
    if (Underflow_Err !== 1'b1 || Reg2 !== 32'h22) begin
      $display("FAIL underflow got unf=%b Reg2=%h exp 1/00000022", Underflow_Err, Reg2);
    end else n_pass++;
  endtask

  task automatic test_r15_and_reset();
    WB_EN_In = 1; Dest_In = 15; WB_Value = 32'h1234; Issue_EN = 1; Issue_Dest = 15;
    #1;
    n_total++;
    Src1 = 15; Src1_Valid = 1; Src2 = 15; Src2_Valid = 1;
    #1;
    if (Reg1 !== 32'h0 || Hazard !== 1'b0) $display("FAIL r15_same got Reg1=%h Hazard=%b exp 0/0", Reg1, Hazard);
    else n_pass++;
    tick();
    idle();
    #1;
    n_total++;
    if (Reg1 !== 32'h0 || Reg2 !== 32'h0 || Hazard !== 1'b0) begin
      $display("FAIL r15_after got Reg1=%h Reg2=%h Hazard=%b exp 0/0/0", Reg1, Reg2, Hazard);
    end else n_pass++;
    Issue_EN = 1; Issue_Dest = 4;
    tick();
    Issue_Dest = 6;
    tick();
    rst = 1; Issue_Dest = 9; WB_EN_In = 1; Dest_In = 9; WB_Value = 32'h99; Flush = 1;
    tick();
    idle();
    Src1 = 4; Src2 = 6; Src1_Valid = 1; Src2_Valid = 1;
    #1;
    n_total++;
    if (Hazard !== 1'b0 || Reg1 !== 32'h0 || Overflow_Err !== 1'b0 || Underflow_Err !== 1'b0) begin
      $display("FAIL mid_reset got Hazard=%b Reg1=%h ovf=%b unf=%b exp 0/0/0/0", Hazard, Reg1, Overflow_Err, Underflow_Err);
    end else n_pass++;
    Src1 = 1; Src2 = 9;
    #1;
    n_total++;
    if (Reg1 !== 32'h0 || Reg2 !== 32'h0) $display("FAIL mid_reset_regs got R1=%h R9=%h exp 0/0", Reg1, Reg2);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst        = ($urandom_range(0, 99) == 0);
      Flush      = ($urandom_range(0, 19) == 0);
      WB_EN_In   = ($urandom_range(0, 2) == 0);
      Dest_In    = 4'($urandom_range(0, 15));
      WB_Value   = $urandom;
      Issue_EN   = ($urandom_range(0, 2) == 0);
      Issue_Dest = 4'($urandom_range(0, 15));
      Src1       = 4'($urandom_range(0, 15));
      Src2       = 4'($urandom_range(0, 15));
      Src1_Valid = 1'($urandom_range(0, 1));
      Src2_Valid = 1'($urandom_range(0, 1));
      #1;
      n_total++;
      if (Reg1 !== m_read(Src1) || Reg2 !== m_read(Src2) || Hazard !== m_hazard() ||
          Overflow_Err !== movf || Underflow_Err !== munf) begin
        $display("FAIL random i=%0d got %h %h %b %b %b exp %h %h %b %b %b", i,
                 Reg1, Reg2, Hazard, Overflow_Err, Underflow_Err,
                 m_read(Src1), m_read(Src2), m_hazard(), movf, munf);
      end else n_pass++;
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_hazard_wb();
    test_overflow();
    test_same_cycle();
    test_flush();
    test_r15_and_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
